cam_init_seq: RTL and testbench

CAM_INIT_SEQ -- requirements
Module: cam_init_seq

---
 rtl/cam_init_seq_pkg.sv | 56 +++++
 rtl/cam_init_seq_if.sv | 15 +
 rtl/cam_init_seq_rom.sv | 35 +++
 rtl/cam_init_seq.sv | 186 ++++++++++++++++++
 tb/tb_cam_init_seq.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_init_seq_pkg.sv
// cam_pkg: shared definitions for the camera init sequencer.
//   - op_e      : table entry opcode (entry[31:30])
//   - state_e   : sequencer FSM encoding (also exported on dbg_state_o)
//   - *_LSB     : REG_CONTRL field offsets {dev, sub, data, 8'h00}
//   - pack_contrl : builds a REG_CONTRL word from a 24-bit WRITE payload
//   - ov_entry  : built-in OV-sensor init table used when the ROM is not overridden
package cam_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_DELAY = 2'b01,
        OP_NOP   = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_DELAY  = 3'd4,
        ST_FIN    = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam int OP_LSB   = 30;
    localparam int DEV_LSB  = 24;
    localparam int SUB_LSB  = 16;
    localparam int DATA_LSB = 8;

    function automatic logic [31:0] pack_contrl(input logic [23:0] payload);
        logic [31:0] w;
        w = '0;
        w[DEV_LSB +: 8]  = payload[23:16];
        w[SUB_LSB +: 8]  = payload[15:8];
        w[DATA_LSB +: 8] = payload[7:0];
        return w;
    endfunction

    // OV-sensor bring-up: soft reset, settle, then format/clock setup.
    function automatic logic [31:0] ov_entry(input int idx);
        logic [31:0] e;
        case (idx)
            0:       e = 32'h0042_1280;  // COM7: soft reset
            1:       e = 32'h4000_0001;  // settle after reset
            2:       e = 32'h0042_1204;  // COM7: RGB output
            3:       e = 32'h0042_1101;  // CLKRC: prescaler
            4:       e = 32'h0042_0C04;  // COM3: scaling enable
            5:       e = 32'h0042_3E19;  // COM14: PCLK divider
            6:       e = 32'h0042_40D0;  // COM15: RGB565 full range
            default: e = 32'hC000_0000;  // END
        endcase
        return e;
    endfunction

endpackage

// File: rtl/cam_init_seq_if.sv
// cam_init_seq_if: request channel from the sequencer to the SCCB master.
//   REG_VALID  : request pending (sequencer -> SCCB master)
//   REG_CONTRL : {dev_id, sub_addr, data, 8'h00}, zero whenever REG_VALID is low
//   REG_READY  : SCCB master idle/accept
// Handshake: REG_VALID rises with REG_CONTRL and both hold steady until the
// first rising HCLK edge where REG_VALID && REG_READY; that edge is the single
// transfer, after which REG_VALID drops. REG_READY may toggle freely.
interface cam_init_seq_if;
    logic        REG_VALID;
    logic [31:0] REG_CONTRL;
    logic        REG_READY;

    modport master (output REG_VALID, output REG_CONTRL, input REG_READY);
    modport slave  (input REG_VALID, input REG_CONTRL, output REG_READY);
endinterface

// File: rtl/cam_init_seq_rom.sv
// cam_init_rom: registered init-table ROM, one 32-bit entry per address,
// data valid one cycle after addr_i. With USE_TABLE=0 the built-in OV table
// is used; otherwise entry i is TABLE[32*i +: 32].
// Ports: clk_i, rst_i (async, active-high), addr_i[ADDR_W], data_o[32].
module cam_init_rom
    import cam_pkg::*;
#(
    parameter int                        ADDR_W    = 6,
    parameter bit                        USE_TABLE = 1'b0,
    parameter logic [32*(2**ADDR_W)-1:0] TABLE     = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [31:0]       data_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0] table_w [DEPTH];
    logic [31:0] data_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign table_w[i] = USE_TABLE ? TABLE[32*i +: 32] : ov_entry(i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= table_w[addr_i];
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/cam_init_seq.sv
// cam_init_seq: walks an init table and issues SCCB register writes/delays.
// Ports:
//   HCLK, HRESET (async, active-high) ; START one-cycle start pulse
//   BUSY  : sequence running          ; DONE : sticky, END reached
//   ERROR : sticky, REG_READY timeout ; ENTRY_IDX : current table index
//   dbg_state_o : FSM state (cam_pkg::state_e encoding)
//   bus   : cam_init_seq_if.master (REG_VALID / REG_CONTRL / REG_READY)
// Optional feature macro CAM_INIT_TIMEOUT_EN: abort with ERROR when a write
// waits TIMEOUT_CYC cycles without REG_READY. Without it, ISSUE waits forever
// and ERROR is tied low.
// ROM_OVERRIDE/ROM_TABLE replace the built-in OV table (entry i at bits 32*i).
module cam_init_seq
    import cam_pkg::*;
#(
    parameter int                        ADDR_W       = 6,
    parameter int                        TIMEOUT_CYC  = 100000,
    parameter int                        DELAY_SHIFT  = 10,
    parameter bit                        ROM_OVERRIDE = 1'b0,
    parameter logic [32*(2**ADDR_W)-1:0] ROM_TABLE    = '0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic [ADDR_W-1:0] ENTRY_IDX,
    output logic [2:0]        dbg_state_o,
    cam_init_seq_if.master    bus
);
    localparam int                DLY_W    = 24 + DELAY_SHIFT;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam int                unused_timeout = TIMEOUT_CYC;

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic [31:0]       contrl_q;
    logic [DLY_W-1:0]  dly_q;
    logic [31:0]       rom_data;
    op_e               op;
    logic              last_entry;
    logic              unused_rsvd;

`ifdef CAM_INIT_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_q;
    logic            err_q;
    assign ERROR = err_q;
`else
    assign ERROR = 1'b0;
`endif

    cam_init_rom #(
        .ADDR_W   (ADDR_W),
        .USE_TABLE(ROM_OVERRIDE),
        .TABLE    (ROM_TABLE)
    ) u_rom (
        .clk_i (HCLK),
        .rst_i (HRESET),
        .addr_i(idx_q),
        .data_o(rom_data)
    );

    assign op          = op_e'(rom_data[OP_LSB +: 2]);
    assign unused_rsvd = ^rom_data[29:24];
    // The top entry completes the table even without an explicit END.
    assign last_entry  = (idx_q == LAST_IDX);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            contrl_q <= '0;
            dly_q    <= '0;
`ifdef CAM_INIT_TIMEOUT_EN
            to_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef CAM_INIT_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= ST_FETCH;
                    end
                end
                // ROM address is idx_q; data lands for DECODE.
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    unique case (op)
                        OP_WRITE: begin
                            valid_q  <= 1'b1;
                            contrl_q <= pack_contrl(rom_data[23:0]);
`ifdef CAM_INIT_TIMEOUT_EN
                            to_q     <= '0;
`endif
                            state_q  <= ST_ISSUE;
                        end
                        OP_DELAY: begin
                            dly_q   <= DLY_W'(rom_data[23:0]) << DELAY_SHIFT;
                            state_q <= ST_DELAY;
                        end
                        OP_END: begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FIN;
                        end
                        default: begin
                            if (last_entry) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_FIN;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= ST_FETCH;
                            end
                        end
                    endcase
                end
                // valid_q is high throughout ISSUE, so READY alone marks the transfer.
                ST_ISSUE: begin
                    if (bus.REG_READY) begin
                        valid_q  <= 1'b0;
                        contrl_q <= '0;
                        if (last_entry) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FIN;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
`ifdef CAM_INIT_TIMEOUT_EN
                    else if (to_q == TO_LAST) begin
                        valid_q  <= 1'b0;
                        contrl_q <= '0;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_ERR;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
`endif
                end
                // dly_q cycles in DELAY; a zero count still spends one cycle.
                ST_DELAY: begin
                    if (dly_q <= DLY_W'(1)) begin
                        if (last_entry) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FIN;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign ENTRY_IDX      = idx_q;
    assign dbg_state_o    = state_q;
    assign bus.REG_VALID  = valid_q;
    assign bus.REG_CONTRL = contrl_q;
endmodule

// File: tb/tb_cam_init_seq.sv
// tb_cam_init_seq: directed bench for cam_init_seq.
// dut1: {WRITE 42_12_80, END}        -- single write, backpressure
// dut2: {DELAY 3, WRITE 3C_01_02, NOP, DELAY 0, END}, DELAY_SHIFT=2,
//       TIMEOUT_CYC=20               -- delay timing, timeout, reset mid-delay
// dut3: ADDR_W=2, four WRITEs, no END -- end-of-table completion
module tb_cam_init_seq;
    import cam_pkg::*;

    localparam logic [511:0] TABLE1 = {{15{32'hC000_0000}}, 32'h0042_1280};
    localparam logic [511:0] TABLE2 = {{11{32'hC000_0000}}, 32'hC000_0000,
                                       32'h4000_0000, 32'h8000_0000,
                                       32'h003C_0102, 32'h4000_0003};
    localparam logic [127:0] TABLE3 = {32'h0042_13A3, 32'h0042_12A2,
                                       32'h0042_11A1, 32'h0042_10A0};

    logic clk = 1'b0;
    logic rst;
    logic start1, start2, start3;
    logic busy1, done1, err1, busy2, done2, err2, busy3, done3, err3;
    logic [3:0] idx1, idx2;
    logic [1:0] idx3;
    logic [2:0] st1, st2, st3;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    cam_init_seq_if bus1();
    cam_init_seq_if bus2();
    cam_init_seq_if bus3();

    always #5 clk = ~clk;

    cam_init_seq #(.ADDR_W(4), .TIMEOUT_CYC(1000), .DELAY_SHIFT(2),
                   .ROM_OVERRIDE(1'b1), .ROM_TABLE(TABLE1)) dut1 (
        .HCLK(clk), .HRESET(rst), .START(start1), .BUSY(busy1), .DONE(done1),
        .ERROR(err1), .ENTRY_IDX(idx1), .dbg_state_o(st1), .bus(bus1));

    cam_init_seq #(.ADDR_W(4), .TIMEOUT_CYC(20), .DELAY_SHIFT(2),
                   .ROM_OVERRIDE(1'b1), .ROM_TABLE(TABLE2)) dut2 (
        .HCLK(clk), .HRESET(rst), .START(start2), .BUSY(busy2), .DONE(done2),
        .ERROR(err2), .ENTRY_IDX(idx2), .dbg_state_o(st2), .bus(bus2));

    cam_init_seq #(.ADDR_W(2), .TIMEOUT_CYC(1000), .DELAY_SHIFT(2),
                   .ROM_OVERRIDE(1'b1), .ROM_TABLE(TABLE3)) dut3 (
        .HCLK(clk), .HRESET(rst), .START(start3), .BUSY(busy3), .DONE(done3),
        .ERROR(err3), .ENTRY_IDX(idx3), .dbg_state_o(st3), .bus(bus3));

    // Returns at the negedge after the START edge (DUT now in FETCH).
    task automatic pulse_start(input int which);
        @(negedge clk);
        start1 = (which == 1);
        start2 = (which == 2);
        start3 = (which == 3);
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        bus1.REG_READY = 1'b0; bus2.REG_READY = 1'b0; bus3.REG_READY = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", err1); end
        checks++; if (idx1 !== 4'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", idx1); end
        checks++; if (bus1.REG_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus1.REG_VALID); end
        checks++; if (bus1.REG_CONTRL !== 32'h0) begin errors++; $display("FAIL rst_contrl: got %h want 0", bus1.REG_CONTRL); end
        checks++; if (st1 !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", st1, ST_IDLE); end
        checks++;
        if ({busy2, done2, err2, idx2, bus2.REG_VALID, bus2.REG_CONTRL, busy3, done3, err3, idx3, bus3.REG_VALID, bus3.REG_CONTRL} !== '0) begin
            errors++; $display("FAIL rst_dut23: got nonzero outputs want all 0");
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus1.REG_VALID !== 1'b0 || st1 !== ST_IDLE) begin
            errors++; $display("FAIL rst_release: got valid=%b state=%0d want 0/%0d", bus1.REG_VALID, st1, ST_IDLE);
        end
    endtask

    task automatic test_single_write;
        int xfer = 0;
        bit got_done = 0;
        bus1.REG_READY = 1'b1;
        pulse_start(1);
        checks++; if (busy1 !== 1'b1 || idx1 !== 4'd0) begin
            errors++; $display("FAIL sw_start: got busy=%b idx=%0d want 1/0", busy1, idx1);
        end
        for (int c = 0; c < 100; c++) begin
            if (bus1.REG_VALID && bus1.REG_READY) begin
                xfer++;
                checks++; if (bus1.REG_CONTRL !== 32'h4212_8000) begin
                    errors++; $display("FAIL sw_contrl: got %h want 42128000", bus1.REG_CONTRL);
                end
            end
            if (done1) begin got_done = 1; break; end
            @(negedge clk);
        end
        checks++; if (!got_done) begin errors++; $display("FAIL sw_done_timeout: got no DONE want DONE within 100 cycles"); end
        checks++; if (xfer !== 1) begin errors++; $display("FAIL sw_xfer_count: got %0d want 1", xfer); end
        checks++; if (idx1 !== 4'd1) begin errors++; $display("FAIL sw_idx: got %0d want 1", idx1); end
        checks++; if (busy1 !== 1'b0 || bus1.REG_CONTRL !== 32'h0) begin
            errors++; $display("FAIL sw_idle_outputs: got busy=%b contrl=%h want 0/0", busy1, bus1.REG_CONTRL);
        end
        @(negedge clk);
        checks++; if (st1 !== ST_IDLE || done1 !== 1'b1) begin
            errors++; $display("FAIL sw_back_idle: got state=%0d done=%b want %0d/1", st1, done1, ST_IDLE);
        end
    endtask

    task automatic test_backpressure;
        bit seen = 0;
        bit got_done = 0;
        int held = 0;
        int xfer = 0;
        int first_cyc = 0;
        logic [31:0] c0;
        bus1.REG_READY = 1'b0;
        pulse_start(1);
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL bp_done_cleared: got %b want 0", done1); end
        for (int c = 0; c < 20; c++) begin
            if (bus1.REG_VALID) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_valid_rise: got no REG_VALID want rise within 20 cycles"); end
        c0 = bus1.REG_CONTRL;
        checks++; if (c0 !== 32'h4212_8000) begin errors++; $display("FAIL bp_contrl: got %h want 42128000", c0); end
        for (int c = 0; c < 50; c++) begin
            if (bus1.REG_VALID === 1'b1 && bus1.REG_CONTRL === c0) held++;
            @(negedge clk);
        end
        checks++; if (held !== 50) begin errors++; $display("FAIL bp_hold: got %0d stable cycles want 50", held); end
        bus1.REG_READY = 1'b1;
        for (int c = 51; c < 120; c++) begin
            if (bus1.REG_VALID && bus1.REG_READY) begin
                xfer++;
                if (first_cyc == 0) first_cyc = c;
            end
            if (done1) begin got_done = 1; break; end
            @(negedge clk);
        end
        checks++; if (!got_done) begin errors++; $display("FAIL bp_done_timeout: got no DONE want DONE"); end
        checks++; if (xfer !== 1) begin errors++; $display("FAIL bp_xfer_count: got %0d want 1", xfer); end
        checks++; if (first_cyc !== 51) begin errors++; $display("FAIL bp_xfer_cycle: got %0d want 51", first_cyc); end
        checks++; if (idx1 !== 4'd1) begin errors++; $display("FAIL bp_idx: got %0d want 1", idx1); end
    endtask

    task automatic test_delay;
        int d0 = 0;
        int d3 = 0;
        int vbad = 0;
        int xfer = 0;
        bit prev_d0 = 0;
        bit got_done = 0;
        bus2.REG_READY = 1'b1;
        pulse_start(2);
        for (int c = 0; c < 300; c++) begin
            start2 = (c == 5);  // START while BUSY must be ignored
            if (prev_d0 && st2 != ST_DELAY) begin
                checks++; if (st2 !== ST_FETCH || idx2 !== 4'd1) begin
                    errors++; $display("FAIL dl_exit: got state=%0d idx=%0d want %0d/1", st2, idx2, ST_FETCH);
                end
            end
            prev_d0 = (st2 == ST_DELAY && idx2 == 4'd0);
            if (st2 == ST_DELAY) begin
                if (idx2 == 4'd0) d0++;
                if (idx2 == 4'd3) d3++;
                if (bus2.REG_VALID !== 1'b0) vbad++;
            end
            if (bus2.REG_VALID && bus2.REG_READY) begin
                xfer++;
                checks++; if (bus2.REG_CONTRL !== 32'h3C01_0200) begin
                    errors++; $display("FAIL dl_contrl: got %h want 3C010200", bus2.REG_CONTRL);
                end
            end
            if (done2) begin got_done = 1; break; end
            @(negedge clk);
        end
        start2 = 1'b0;
        checks++; if (!got_done) begin errors++; $display("FAIL dl_done_timeout: got no DONE want DONE"); end
        checks++; if (d0 !== 12) begin errors++; $display("FAIL dl_count3: got %0d cycles want 12", d0); end
        checks++; if (d3 !== 1) begin errors++; $display("FAIL dl_count0: got %0d cycles want 1", d3); end
        checks++; if (vbad !== 0) begin errors++; $display("FAIL dl_valid_low: got %0d valid cycles want 0", vbad); end
        checks++; if (xfer !== 1) begin errors++; $display("FAIL dl_xfer_count: got %0d want 1", xfer); end
        checks++; if (idx2 !== 4'd4 || busy2 !== 1'b0) begin
            errors++; $display("FAIL dl_end: got idx=%0d busy=%b want 4/0", idx2, busy2);
        end
    endtask

    task automatic test_timeout;
        int vhigh = 0;
        bit flag = 0;
        bus2.REG_READY = 1'b0;
        pulse_start(2);
        checks++; if (done2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++; $display("FAIL to_start: got done=%b busy=%b want 0/1", done2, busy2);
        end
`ifdef CAM_INIT_TIMEOUT_EN
        for (int c = 0; c < 200; c++) begin
            if (err2) begin flag = 1; break; end
            if (bus2.REG_VALID) vhigh++;
            @(negedge clk);
        end
        checks++; if (!flag) begin errors++; $display("FAIL to_error: got ERROR=0 want 1 within 200 cycles"); end
        checks++; if (vhigh !== 20) begin errors++; $display("FAIL to_cycles: got %0d valid cycles want 20", vhigh); end
        checks++; if (bus2.REG_VALID !== 1'b0 || busy2 !== 1'b0 || bus2.REG_CONTRL !== 32'h0) begin
            errors++; $display("FAIL to_outputs: got valid=%b busy=%b contrl=%h want 0/0/0", bus2.REG_VALID, busy2, bus2.REG_CONTRL);
        end
        checks++; if (idx2 !== 4'd1) begin errors++; $display("FAIL to_idx: got %0d want 1", idx2); end
        @(negedge clk);
        checks++; if (st2 !== ST_IDLE || err2 !== 1'b1) begin
            errors++; $display("FAIL to_sticky: got state=%0d err=%b want %0d/1", st2, err2, ST_IDLE);
        end
`else
        for (int c = 0; c < 40; c++) begin
            if (bus2.REG_VALID) begin flag = 1; break; end
            @(negedge clk);
        end
        checks++; if (!flag) begin errors++; $display("FAIL to_valid_rise: got no REG_VALID want rise"); end
        for (int c = 0; c < 40; c++) begin
            if (bus2.REG_VALID === 1'b1 && err2 === 1'b0 && busy2 === 1'b1) vhigh++;
            @(negedge clk);
        end
        checks++; if (vhigh !== 40) begin errors++; $display("FAIL to_wait_forever: got %0d waiting cycles want 40", vhigh); end
        bus2.REG_READY = 1'b1;
        flag = 0;
        for (int c = 0; c < 100; c++) begin
            if (done2) begin flag = 1; break; end
            @(negedge clk);
        end
        checks++; if (!flag || idx2 !== 4'd4) begin
            errors++; $display("FAIL to_finish: got done=%b idx=%0d want 1/4", done2, idx2);
        end
`endif
    endtask

    task automatic test_reset_mid_delay;
        bit flag = 0;
        int d0 = 0;
        int xfer = 0;
        bus2.REG_READY = 1'b1;
        pulse_start(2);
        for (int c = 0; c < 20; c++) begin
            if (st2 == ST_DELAY) begin flag = 1; break; end
            @(negedge clk);
        end
        checks++; if (!flag) begin errors++; $display("FAIL rd_reach_delay: got state=%0d want %0d", st2, ST_DELAY); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy2, done2, err2, idx2, bus2.REG_VALID, bus2.REG_CONTRL} !== '0 || st2 !== ST_IDLE) begin
            errors++; $display("FAIL rd_reset_vals: got busy=%b done=%b err=%b idx=%0d valid=%b state=%0d want all 0/IDLE",
                               busy2, done2, err2, idx2, bus2.REG_VALID, st2);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (st2 !== ST_IDLE || bus2.REG_VALID !== 1'b0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL rd_after_release: got state=%0d valid=%b busy=%b want IDLE/0/0", st2, bus2.REG_VALID, busy2);
        end
        pulse_start(2);
        checks++; if (idx2 !== 4'd0 || st2 !== ST_FETCH) begin
            errors++; $display("FAIL rd_restart: got idx=%0d state=%0d want 0/%0d", idx2, st2, ST_FETCH);
        end
        flag = 0;
        for (int c = 0; c < 300; c++) begin
            if (st2 == ST_DELAY && idx2 == 4'd0) d0++;
            if (bus2.REG_VALID && bus2.REG_READY) xfer++;
            if (done2) begin flag = 1; break; end
            @(negedge clk);
        end
        checks++; if (!flag || d0 !== 12 || xfer !== 1 || idx2 !== 4'd4) begin
            errors++; $display("FAIL rd_rerun: got done=%b delay=%0d xfer=%0d idx=%0d want 1/12/1/4", flag, d0, xfer, idx2);
        end
    endtask

    task automatic test_table_end;
        int xfer = 0;
        bit got_done = 0;
        logic [31:0] exp;
        exp_q.push_back(32'h4210_A000);
        exp_q.push_back(32'h4211_A100);
        exp_q.push_back(32'h4212_A200);
        exp_q.push_back(32'h4213_A300);
        bus3.REG_READY = 1'b1;
        pulse_start(3);
        for (int c = 0; c < 100; c++) begin
            start3 = (c == 8);  // mid-run START must be ignored
            if (bus3.REG_VALID && bus3.REG_READY) begin
                xfer++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL te_extra_xfer: got %h want no transfer", bus3.REG_CONTRL);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus3.REG_CONTRL !== exp) begin
                        errors++; $display("FAIL te_contrl: got %h want %h", bus3.REG_CONTRL, exp);
                    end
                end
            end
            if (done3) begin got_done = 1; break; end
            @(negedge clk);
        end
        start3 = 1'b0;
        checks++; if (!got_done) begin errors++; $display("FAIL te_done_timeout: got no DONE want DONE"); end
        checks++; if (xfer !== 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL te_xfer_count: got %0d want 4", xfer);
        end
        checks++; if (idx3 !== 2'd3 || busy3 !== 1'b0) begin
            errors++; $display("FAIL te_idx: got idx=%0d busy=%b want 3/0", idx3, busy3);
        end
        repeat (2) @(negedge clk);
        checks++; if (st3 !== ST_IDLE || idx3 !== 2'd3 || done3 !== 1'b1) begin
            errors++; $display("FAIL te_no_wrap: got state=%0d idx=%0d done=%b want IDLE/3/1", st3, idx3, done3);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_delay();
        test_timeout();
        test_reset_mid_delay();
        test_table_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
